instqueue_multi: RTL and testbench
==================================

Name: instqueue_multi

Overview:
- Parametrised instruction queue between instruction fetch and decoder; successor of the single-issue queue.
- Circular buffer of DEPTH entries of {instruction, pc}; accepts at most one fetched instruction per cycle.
- Hands up to ISSUE oldest entries per cycle to the decoder, sized by a downstream slot count.
- Adds a full/occupancy back-pressure path to fetch and a single unified flush input.

Parameters:
IW, 32, instruction width in bits
AW, 32, pc width in bits
DEPTH, 16, entry count; power of 2, DEPTH >= 2*ISSUE
ISSUE, 2, maximum entries dequeued per cycle; 1..4
CW, $clog2(DEPTH+1), occupancy counter width (derived, localparam)
SW, $clog2(ISSUE+1), slot-count width (derived, localparam)

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
rdy_in  input  1  global ready; low = hold all state and outputs
flush_in  input  1  flush (ROB mispredict / decoder / branch-predictor redirect, ORed upstream)
if_instqueue_en_in  input  1  fetch presents an instruction this cycle
if_instqueue_inst_in  input  IW  instruction
if_instqueue_pc_in  input  AW  pc of instruction
instqueue_if_full_out  output  1  queue full; fetch must not assert en
decoder_instqueue_slots_in  input  SW  entries downstream accepts this cycle (0..ISSUE)
instqueue_decoder_valid_out  output  ISSUE  per-lane valid, thermometer from lane 0
instqueue_decoder_inst_out  output  ISSUE*IW  lane k at bits [k*IW +: IW]; lane 0 oldest
instqueue_decoder_pc_out  output  ISSUE*AW  lane k at bits [k*AW +: AW]
instqueue_count_out  output  CW  current occupancy

Behaviour:
- State: inst/pc arrays, head, tail (log2 DEPTH bits, natural wrap), count (CW bits).
- Reset (rst_n_in low, asynchronous): head=tail=count=0; valid_out=0; inst_out/pc_out=0; full_out=0. Array contents need no reset. Reset mid-operation discards all entries immediately.
- rdy_in low: no state or output changes; inputs ignored.
- Occupancy outputs: instqueue_if_full_out = (count == DEPTH); instqueue_count_out = count. Both combinational from registered count.
- Flush (rdy_in high, flush_in high): next edge head=tail=count=0, valid_out=0, data outputs 0. Same-cycle enqueue and dequeue are discarded. Flush has priority over everything.
- Enqueue (no flush): accepted iff if_instqueue_en_in && count < DEPTH, using start-of-cycle count. No same-cycle pass-through when full, even if a dequeue frees space. Accepted: write entry at tail, tail+1. En while full: entry dropped, no state change.
- Dequeue (no flush): n = min(slots_in, count), start-of-cycle count. Slots_in > ISSUE is treated as ISSUE.
  - Next edge: lane k<n gets entry at (head+k) mod DEPTH with valid=1; lanes k>=n get valid=0 and data 0.
  - head += n.
  - An entry enqueued this cycle is never dequeued this cycle. Empty queue yields 1-cycle minimum latency from enqueue edge to decoder output edge.
- Count next = count + accepted_enq - n; never exceeds DEPTH, never negative.
- Outputs are registered and valid for exactly one cycle per dequeue; decoder must capture them. Valid is not held across cycles except under rdy_in low.
- Wrap-around: head+k crossing DEPTH-1 wraps to 0 within one dequeue group; order preserved.

Test Plan:
- Reset then enqueue pc 0x00,0x04,0x08 on 3 cycles, slots=0; then slots=2 one cycle -> next edge valid=2'b11, pc lanes 0x00/0x04, count 3->1; next cycle slots=2 -> valid=2'b01, pc 0x08, count 0.
- Fill 16 entries, slots=0 -> full_out=1, count=16. Assert en with pc 0x100 -> dropped. Drain all 16 -> pc order preserved; 0x100 never appears.
- Full queue, en=1 and slots=1 same cycle -> enqueue rejected, one entry dequeued, count 16->15, full_out falls.
- Head at 15, count=4, slots=2 -> lanes carry entries 15 and 0; head=1.
- Count=5, flush_in with en=1 and slots=2 -> next edge count=0, valid=0, enqueued item absent. Queue restarts at index 0.
- Mid-stream, rdy_in low 3 cycles -> all outputs and count frozen. rst_n_in pulsed low mid-cycle -> outputs 0 before the next clock edge.

Source files
------------

// File: rtl/instqueue_multi.sv
// Multi-issue instruction queue: circular buffer between fetch and decode that
// hands up to ISSUE oldest entries per cycle to registered decoder lanes.
module instqueue_multi #(
    parameter int IW    = 32,
    parameter int AW    = 32,
    parameter int DEPTH = 16,
    parameter int ISSUE = 2,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int SW   = $clog2(ISSUE + 1)
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                rdy_in,
    input  logic                flush_in,
    input  logic                if_instqueue_en_in,
    input  logic [IW-1:0]       if_instqueue_inst_in,
    input  logic [AW-1:0]       if_instqueue_pc_in,
    output logic                instqueue_if_full_out,
    input  logic [SW-1:0]       decoder_instqueue_slots_in,
    output logic [ISSUE-1:0]    instqueue_decoder_valid_out,
    output logic [ISSUE*IW-1:0] instqueue_decoder_inst_out,
    output logic [ISSUE*AW-1:0] instqueue_decoder_pc_out,
    output logic [CW-1:0]       instqueue_count_out
);
    localparam int PW = $clog2(DEPTH);

    logic [IW-1:0]       inst_mem [DEPTH];
    logic [AW-1:0]       pc_mem   [DEPTH];
    logic [PW-1:0]       head;
    logic [PW-1:0]       tail;
    logic [CW-1:0]       count;
    logic                enq_p0;
    logic [SW-1:0]       deq_n_p0;
    logic [ISSUE-1:0]    vld_p1;
    logic [ISSUE*IW-1:0] inst_p1;
    logic [ISSUE*AW-1:0] pc_p1;

    // Dequeue size: slot request clamped to ISSUE and to the current occupancy.
    function automatic logic [SW-1:0] sat_deq(input logic [SW-1:0] slots,
                                              input logic [CW-1:0] cnt);
        int n;
        n = int'(slots);
        if (n > ISSUE)
            n = ISSUE;
        if (n > int'(cnt))
            n = int'(cnt);
        return SW'(n);
    endfunction

    // Stage p0: accept/dequeue decisions from start-of-cycle occupancy
    always_comb begin
        enq_p0   = if_instqueue_en_in && (count < CW'(DEPTH));
        deq_n_p0 = sat_deq(decoder_instqueue_slots_in, count);
    end

    assign instqueue_if_full_out = (count == CW'(DEPTH));
    assign instqueue_count_out   = count;

    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush_in && enq_p0) begin
            inst_mem[tail] <= if_instqueue_inst_in;
            pc_mem[tail]   <= if_instqueue_pc_in;
        end
    end

    // Stage p1: pointer/count update and registered decoder lanes
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            vld_p1  <= '0;
            inst_p1 <= '0;
            pc_p1   <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head    <= '0;
                tail    <= '0;
                count   <= '0;
                vld_p1  <= '0;
                inst_p1 <= '0;
                pc_p1   <= '0;
            end else begin
                tail  <= tail + PW'(enq_p0);
                head  <= head + PW'(deq_n_p0);
                count <= count + CW'(enq_p0) - CW'(deq_n_p0);
                for (int k = 0; k < ISSUE; k++) begin
                    if (k < int'(deq_n_p0)) begin
                        vld_p1[k]            <= 1'b1;
                        inst_p1[k*IW +: IW]  <= inst_mem[head + PW'(k)];
                        pc_p1[k*AW +: AW]    <= pc_mem[head + PW'(k)];
                    end else begin
                        vld_p1[k]            <= 1'b0;
                        inst_p1[k*IW +: IW]  <= '0;
                        pc_p1[k*AW +: AW]    <= '0;
                    end
                end
            end
        end
    end

    assign instqueue_decoder_valid_out = vld_p1;
    assign instqueue_decoder_inst_out  = inst_p1;
    assign instqueue_decoder_pc_out    = pc_p1;

endmodule

// File: tb/tb_instqueue_multi.sv
// Scoreboard bench for instqueue_multi: a queue-based reference model predicts
// each cycle's decoder lanes and occupancy; a negedge monitor compares them.
module tb_instqueue_multi;
    localparam int IW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 16;
    localparam int ISSUE = 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int SW    = $clog2(ISSUE + 1);

    logic                clk_in = 1'b0;
    logic                rst_n_in;
    logic                rdy_in;
    logic                flush_in;
    logic                if_instqueue_en_in;
    logic [IW-1:0]       if_instqueue_inst_in;
    logic [AW-1:0]       if_instqueue_pc_in;
    logic                instqueue_if_full_out;
    logic [SW-1:0]       decoder_instqueue_slots_in;
    logic [ISSUE-1:0]    instqueue_decoder_valid_out;
    logic [ISSUE*IW-1:0] instqueue_decoder_inst_out;
    logic [ISSUE*AW-1:0] instqueue_decoder_pc_out;
    logic [CW-1:0]       instqueue_count_out;

    instqueue_multi #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .ISSUE(ISSUE)) dut (
        .clk_in                      (clk_in),
        .rst_n_in                    (rst_n_in),
        .rdy_in                      (rdy_in),
        .flush_in                    (flush_in),
        .if_instqueue_en_in          (if_instqueue_en_in),
        .if_instqueue_inst_in        (if_instqueue_inst_in),
        .if_instqueue_pc_in          (if_instqueue_pc_in),
        .instqueue_if_full_out       (instqueue_if_full_out),
        .decoder_instqueue_slots_in  (decoder_instqueue_slots_in),
        .instqueue_decoder_valid_out (instqueue_decoder_valid_out),
        .instqueue_decoder_inst_out  (instqueue_decoder_inst_out),
        .instqueue_decoder_pc_out    (instqueue_decoder_pc_out),
        .instqueue_count_out         (instqueue_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [ISSUE-1:0]    v;
        logic [ISSUE*IW-1:0] i;
        logic [ISSUE*AW-1:0] p;
        int                  cnt;
    } rec_t;

    rec_t                sb[$];
    rec_t                mr;
    logic [IW-1:0]       mi[$];
    logic [AW-1:0]       mp[$];
    logic [ISSUE-1:0]    ev;
    logic [ISSUE*IW-1:0] ei;
    logic [ISSUE*AW-1:0] ep;
    int                  n_chk = 0;
    int                  n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk_inst(input logic [AW-1:0] pc);
        return IW'(pc * 32'h9E37_79B1 + 32'd1);
    endfunction

    // One clock of stimulus; the model predicts the state after the coming edge.
    task automatic step(input logic en, input logic [AW-1:0] pc, input int slots,
                        input logic fl, input logic rdy);
        rec_t r;
        int   n;
        int   sz;
        rdy_in                     = rdy;
        flush_in                   = fl;
        if_instqueue_en_in         = en;
        if_instqueue_pc_in         = pc;
        if_instqueue_inst_in       = mk_inst(pc);
        decoder_instqueue_slots_in = SW'(slots);
        if (rdy) begin
            if (fl) begin
                mi.delete();
                mp.delete();
                ev = '0; ei = '0; ep = '0;
            end else begin
                sz = mi.size();
                n  = (slots > ISSUE) ? ISSUE : slots;
                if (n > sz) n = sz;
                ev = '0; ei = '0; ep = '0;
                for (int k = 0; k < n; k++) begin
                    ev[k]           = 1'b1;
                    ei[k*IW +: IW]  = mi.pop_front();
                    ep[k*AW +: AW]  = mp.pop_front();
                end
                if (en && sz < DEPTH) begin
                    mi.push_back(mk_inst(pc));
                    mp.push_back(pc);
                end
            end
        end
        r = '{ev, ei, ep, mi.size()};
        @(posedge clk_in);
        sb.push_back(r);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 128'(instqueue_decoder_valid_out), 128'd0);
        chk({tag, "_inst"},  128'(instqueue_decoder_inst_out),  128'd0);
        chk({tag, "_pc"},    128'(instqueue_decoder_pc_out),    128'd0);
        chk({tag, "_count"}, 128'(instqueue_count_out),         128'd0);
        chk({tag, "_full"},  128'(instqueue_if_full_out),       128'd0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        @(negedge clk_in);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk_zero("async_rst");
        mi.delete();
        mp.delete();
        ev = '0; ei = '0; ep = '0;
        #1;
        rst_n_in = 1'b1;
    endtask

    always @(negedge clk_in) begin
        if (sb.size() > 0) begin
            mr = sb.pop_front();
            chk("valid", 128'(instqueue_decoder_valid_out), 128'(mr.v));
            chk("inst",  128'(instqueue_decoder_inst_out),  128'(mr.i));
            chk("pc",    128'(instqueue_decoder_pc_out),    128'(mr.p));
            chk("count", 128'(instqueue_count_out),         128'(mr.cnt));
            chk("full",  128'(instqueue_if_full_out),       128'(mr.cnt == DEPTH));
        end
    end

    initial begin
        rst_n_in = 1'b0;
        rdy_in = 1'b0; flush_in = 1'b0; if_instqueue_en_in = 1'b0;
        if_instqueue_inst_in = '0; if_instqueue_pc_in = '0;
        decoder_instqueue_slots_in = '0;
        ev = '0; ei = '0; ep = '0;
        #12;
        chk_zero("reset");
        rst_n_in = 1'b1;

        // Basic enqueue of three, then two dequeue groups
        step(1, 32'h00, 0, 0, 1);
        step(1, 32'h04, 0, 0, 1);
        step(1, 32'h08, 0, 0, 1);
        step(0, 32'h0,  2, 0, 1);
        step(0, 32'h0,  2, 0, 1);
        step(0, 32'h0,  0, 0, 1);

        // Fill to full, drop an extra, drain in order
        for (int i = 0; i < DEPTH; i++) step(1, 32'h200 + 32'(4*i), 0, 0, 1);
        step(1, 32'h100, 0, 0, 1);
        for (int i = 0; i < DEPTH/2 + 1; i++) step(0, 32'h0, 2, 0, 1);

        // Full with simultaneous enqueue and single dequeue
        for (int i = 0; i < DEPTH; i++) step(1, 32'h300 + 32'(4*i), 0, 0, 1);
        step(1, 32'h3F0, 1, 0, 1);
        step(0, 32'h0, 0, 0, 1);
        for (int i = 0; i < DEPTH/2 + 1; i++) step(0, 32'h0, 3, 0, 1);

        // Move head to index 15, then a dequeue group that wraps
        async_reset();
        for (int i = 0; i < DEPTH - 1; i++) step(1, 32'h400 + 32'(4*i), 2, 0, 1);
        step(0, 32'h0, 2, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 32'h500 + 32'(4*i), 0, 0, 1);
        step(0, 32'h0, 2, 0, 1);
        step(0, 32'h0, 2, 0, 1);

        // Flush with count 5 and concurrent enqueue/dequeue, then restart
        for (int i = 0; i < 5; i++) step(1, 32'h600 + 32'(4*i), 0, 0, 1);
        step(1, 32'h6F0, 2, 1, 1);
        step(1, 32'h700, 0, 0, 1);
        step(1, 32'h704, 0, 0, 1);
        step(0, 32'h0, 2, 0, 1);
        step(0, 32'h0, 0, 0, 1);

        // Stall: rdy low for three cycles mid-stream
        for (int i = 0; i < 4; i++) step(1, 32'h800 + 32'(4*i), 0, 0, 1);
        step(0, 32'h0, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 32'h8F0, 2, 1'($urandom_range(0, 1)), 0);
        step(0, 32'h0, 2, 0, 1);

        // Reset mid-operation discards everything
        async_reset();
        step(0, 32'h0, 2, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 32'($urandom),
                 int'($urandom_range(0, (1 << SW) - 1)),
                 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 7) != 0));
        end
        for (int i = 0; i < DEPTH; i++) step(0, 32'h0, ISSUE, 0, 1);

        @(negedge clk_in);
        #1;
        chk("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
